timing_decode: RTL and testbench
================================

TIMING_DECODE -- requirements
Module: timing_decode

Interface
REQ-001 SHALL have port CLK  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port RESET_N  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port CLEAR  input  1  synchronous front-panel clear, active-high.
REQ-004 SHALL have port SOFT_RESET  input  1  end-of-instruction strobe from control logic.
REQ-005 SHALL have port IR_LOAD  input  1  capture BUS_IN into IR.
REQ-006 SHALL have port BUS_IN  input  8  internal data bus.
REQ-007 SHALL have port Z_LOAD  input  1  update Z flag (driven by AC_LOAD).
REQ-008 SHALL have port Z_IN  input  1  ALU-result-is-zero.
REQ-009 SHALL have ports T0..T7  output  1 each  one-hot timing states.
REQ-010 SHALL have ports INOP, ILDAC, ISTAC, IMVAC, IMOVR, IJUMP, IJMPZ, IJPNZ, IADD, ISUB, IINAC, ICLAC, IAND, IOR, IXOR, INOT  output  1 each  instruction decodes.
REQ-011 SHALL have port Z  output  1  registered zero flag.
REQ-012 SHALL have port IR  output  8  registered instruction.
REQ-013 SHALL have port ILLEGAL  output  1  IR holds an undefined opcode.
REQ-014 SHALL have port TIMEOUT  output  1  sticky: sequence reached T7 with no SOFT_RESET.

Function
REQ-015 SHALL hold a 3-bit state counter; T0..T7 SHALL be its combinational one-hot decode, exactly one high at all times.
REQ-016 Next-state priority SHALL be: CLEAR -> T0; else SOFT_RESET -> T0; else (T3 and ILLEGAL) -> T0; else T7 -> T0 and set TIMEOUT; else state+1.
REQ-017 SOFT_RESET asserted in T0 SHALL leave state at T0.
REQ-018 IR SHALL load BUS_IN on an edge with IR_LOAD=1 and CLEAR=0; otherwise hold.
REQ-019 Decodes SHALL be combinational from IR, valid only when IR[7:4]=0000: IR[3:0] 0..15 map to NOP, LDAC, STAC, MVAC, MOVR, JUMP, JMPZ, JPNZ, ADD, SUB, INAC, CLAC, AND, OR, XOR, NOT respectively.
REQ-020 When IR[7:4]!=0000 all sixteen decodes SHALL be 0 and ILLEGAL=1; otherwise ILLEGAL=0 and exactly one decode is 1.
REQ-021 Z SHALL load Z_IN on an edge with Z_LOAD=1 and CLEAR=0; otherwise hold.
REQ-022 CLEAR SHALL, at the edge: state=T0, IR=0x00, Z=1 (accumulator is cleared to zero), TIMEOUT=0; CLEAR overrides IR_LOAD, Z_LOAD, SOFT_RESET in the same cycle.
REQ-023 CLEAR held for N cycles SHALL hold T0 for N cycles; sequencing SHALL resume T1 on the first edge after CLEAR deasserts.
REQ-024 TIMEOUT SHALL remain 1 once set until CLEAR or reset.
REQ-025 Outputs SHALL have no latency beyond the register: T*/decodes/ILLEGAL change in the same cycle as the register update.

Reset
REQ-026 RESET_N=0 SHALL immediately, independent of CLK, force state=T0, IR=0x00, Z=1, TIMEOUT=0; hence INOP=1, ILLEGAL=0.
REQ-027 Reset deasserted mid-instruction SHALL restart from T0 with the first subsequent edge moving to T1.

Verification
REQ-028 Reset, then 3 edges with SOFT_RESET=0 -> T0, T1, T2, T3 observed in order, INOP=1.
REQ-029 IR_LOAD=1, BUS_IN=0x01 at T2 edge; SOFT_RESET=1 at T7 -> ILDAC=1 from T3, sequence T3..T7 then T0, TIMEOUT=0.
REQ-030 BUS_IN=0x35 loaded at T2 -> ILLEGAL=1, all decodes 0, state T3 then T0 next edge, TIMEOUT=0.
REQ-031 IR=0x00 (NOP), SOFT_RESET held 0 through T7 -> wrap to T0, TIMEOUT=1 and stays 1 until CLEAR pulse.
REQ-032 CLEAR=1 together with IR_LOAD=1 (BUS_IN=0x08), Z_LOAD=1, Z_IN=0 at T4 -> next cycle T0, IR=0x00, Z=1.
REQ-033 RESET_N pulsed low between edges during T5 -> outputs T0, IR=0x00, Z=1 before the next CLK edge.

Source files
------------

// File: rtl/timing_decode.sv
// timing_decode: 3-bit T-state sequencer with IR/Z registers, opcode decode and sticky timeout.
module timing_decode (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CLEAR,
  input  logic       SOFT_RESET,
  input  logic       IR_LOAD,
  input  logic [7:0] BUS_IN,
  input  logic       Z_LOAD,
  input  logic       Z_IN,
  output logic       T0,
  output logic       T1,
  output logic       T2,
  output logic       T3,
  output logic       T4,
  output logic       T5,
  output logic       T6,
  output logic       T7,
  output logic       INOP,
  output logic       ILDAC,
  output logic       ISTAC,
  output logic       IMVAC,
  output logic       IMOVR,
  output logic       IJUMP,
  output logic       IJMPZ,
  output logic       IJPNZ,
  output logic       IADD,
  output logic       ISUB,
  output logic       IINAC,
  output logic       ICLAC,
  output logic       IAND,
  output logic       IOR,
  output logic       IXOR,
  output logic       INOT,
  output logic       Z,
  output logic [7:0] IR,
  output logic       ILLEGAL,
  output logic       TIMEOUT
);
  logic [2:0] state, state_nxt;
  logic       to_set;
  always_comb begin
    state_nxt = (CLEAR || SOFT_RESET || (state == 3'd3 && ILLEGAL)) ? 3'd0 : state + 3'd1;
    to_set    = !CLEAR && !SOFT_RESET && state == 3'd7;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= 3'd0;
      IR      <= 8'h00;
      Z       <= 1'b1;
      TIMEOUT <= 1'b0;
    end else begin
      state   <= state_nxt;
      IR      <= CLEAR ? 8'h00 : IR_LOAD ? BUS_IN : IR;
      Z       <= CLEAR ? 1'b1 : Z_LOAD ? Z_IN : Z;
      TIMEOUT <= CLEAR ? 1'b0 : TIMEOUT | to_set;
    end
  end
  assign {T7, T6, T5, T4, T3, T2, T1, T0} = 8'd1 << state;
  assign ILLEGAL = |IR[7:4];
  assign {INOT, IXOR, IOR, IAND, ICLAC, IINAC, ISUB, IADD,
          IJPNZ, IJMPZ, IJUMP, IMOVR, IMVAC, ISTAC, ILDAC, INOP} = ILLEGAL ? 16'd0 : 16'd1 << IR[3:0];
endmodule

// File: tb/tb_timing_decode.sv
// tb_timing_decode: directed and random stimulus against an arithmetic reference model.
module tb_timing_decode;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CLEAR = 1'b0;
  logic       SOFT_RESET = 1'b0;
  logic       IR_LOAD = 1'b0;
  logic [7:0] BUS_IN = 8'h00;
  logic       Z_LOAD = 1'b0;
  logic       Z_IN = 1'b0;
  logic       T0, T1, T2, T3, T4, T5, T6, T7;
  logic       INOP, ILDAC, ISTAC, IMVAC, IMOVR, IJUMP, IJMPZ, IJPNZ;
  logic       IADD, ISUB, IINAC, ICLAC, IAND, IOR, IXOR, INOT;
  logic       Z, ILLEGAL, TIMEOUT;
  logic [7:0] IR;
  int         total = 0;
  int         bad = 0;
  int         m_st;
  int         m_ir;
  bit         m_z, m_to;
  logic [7:0]  t_vec;
  logic [15:0] d_vec;

  timing_decode dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .SOFT_RESET(SOFT_RESET),
    .IR_LOAD(IR_LOAD), .BUS_IN(BUS_IN), .Z_LOAD(Z_LOAD), .Z_IN(Z_IN),
    .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6), .T7(T7),
    .INOP(INOP), .ILDAC(ILDAC), .ISTAC(ISTAC), .IMVAC(IMVAC), .IMOVR(IMOVR),
    .IJUMP(IJUMP), .IJMPZ(IJMPZ), .IJPNZ(IJPNZ), .IADD(IADD), .ISUB(ISUB),
    .IINAC(IINAC), .ICLAC(ICLAC), .IAND(IAND), .IOR(IOR), .IXOR(IXOR), .INOT(INOT),
    .Z(Z), .IR(IR), .ILLEGAL(ILLEGAL), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;
  assign t_vec = {T7, T6, T5, T4, T3, T2, T1, T0};
  assign d_vec = {INOT, IXOR, IOR, IAND, ICLAC, IINAC, ISUB, IADD,
                  IJPNZ, IJMPZ, IJUMP, IMOVR, IMVAC, ISTAC, ILDAC, INOP};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, {8'h00, t_vec}, 16'(1 << m_st));
    chk({tag, ".ir"}, {8'h00, IR}, 16'(m_ir));
    chk({tag, ".dec"}, d_vec, (m_ir < 16) ? 16'(1 << m_ir) : 16'h0000);
    chk({tag, ".illegal"}, {15'd0, ILLEGAL}, {15'd0, m_ir >= 16});
    chk({tag, ".z"}, {15'd0, Z}, {15'd0, m_z});
    chk({tag, ".timeout"}, {15'd0, TIMEOUT}, {15'd0, m_to});
  endtask

  task automatic model_reset();
    m_st = 0; m_ir = 0; m_z = 1'b1; m_to = 1'b0;
  endtask

  task automatic step(input string tag, input bit c, input bit s, input bit l,
                      input logic [7:0] b, input bit zl, input bit zi);
    CLEAR = c; SOFT_RESET = s; IR_LOAD = l; BUS_IN = b; Z_LOAD = zl; Z_IN = zi;
    if (c) model_reset();
    else begin
      if (s || (m_st == 3 && m_ir >= 16)) m_st = 0;
      else if (m_st == 7) begin m_st = 0; m_to = 1'b1; end
      else m_st = m_st + 1;
      if (l) m_ir = int'(b);
      if (zl) m_z = zi;
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step("nop_wrap", 0, 0, 0, 8'h00, 0, 0);
    step("to_sticky", 0, 0, 0, 8'h00, 0, 0);
    step("to_sticky2", 0, 1, 0, 8'h00, 0, 0);
    step("clear_to", 1, 0, 0, 8'h00, 0, 0);
    step("t1", 0, 0, 0, 8'h00, 0, 0);
    step("ldac_load", 0, 0, 1, 8'h01, 0, 0);
    for (int i = 0; i < 4; i++) step("ldac_seq", 0, 0, 0, 8'h00, 0, 0);
    step("ldac_soft", 0, 1, 0, 8'h00, 0, 0);
    step("soft_t0", 0, 1, 0, 8'h00, 0, 0);
    step("t1b", 0, 0, 0, 8'h00, 0, 0);
    step("ill_load", 0, 0, 1, 8'h35, 0, 0);
    step("ill_abort", 0, 0, 0, 8'h00, 0, 0);
    step("clr_hold", 1, 0, 0, 8'h00, 0, 0);
    step("clr_hold2", 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step("to_t4", 0, 0, 0, 8'h00, i == 1, 0);
    step("clr_over", 1, 1, 1, 8'h08, 1, 0);
    for (int i = 0; i < 5; i++) step("to_t5", 0, 0, i == 1, 8'h0A, i == 2, 0);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #2;
    RESET_N = 1'b1;
    step("post_rst", 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(3) != 0) b[7:4] = 4'h0;
      step("rand", $urandom_range(19) == 0, $urandom_range(9) == 0,
           $urandom_range(3) == 0, b, $urandom_range(2) == 0, 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
